dmem_responder: RTL and testbench

- Memory-side responder for the core's data-memory port.
- Accepts load/store requests over a valid/ready request channel, with a configurable number of wait states.
- Returns read data and a completion/error status over a valid/ready response channel.
- Sits between the core's load/store path and on-chip word-addressed RAM, giving the core a multi-cycle memory model.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_ram.sv | 41 ++++
 rtl/dmem_responder.sv | 139 +++++++++++++
 tb/tb_dmem_responder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding,
// word/strobe widths and the wait-state counter type.
package dmem_pkg;

   localparam int XLEN   = 32;
   localparam int STRB_W = 4;
   localparam int CNT_W  = 4;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/dmem_ram.sv
// Word-addressed RAM with per-byte write enables and a registered read port.
// One access per transaction: when acc is high the array is written (we) and
// the read flop loads either the addressed word (re) or zero, so the flop
// output can drive the response data directly.
module dmem_ram
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           acc,
   input  logic                           re,
   input  logic                           we,
   input  logic [STRB_W-1:0]              wstrb,
   input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
   input  logic [XLEN-1:0]                wdata,
   output logic [XLEN-1:0]                rdata
);

   logic [XLEN-1:0] r_mem [DEPTH_WORDS];
   logic [XLEN-1:0] r_rdata;

   // Byte-masked write into the storage array (contents survive reset)
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (wstrb[b]) r_mem[idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   // Read flop: addressed word for loads, zero for stores and faulted requests
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)   r_rdata <= '0;
      else if (acc) r_rdata <= re ? r_mem[idx] : '0;
   end

   assign rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store over a valid/ready request
// channel, waits WAIT_CYCLES cycles, performs the RAM access once on the
// edge that enters RESP, then holds the response until the core takes it.
// Optional macro DMEM_ERR_EN enables misalignment / out-of-range faulting;
// without it the word index wraps and rsp_err is tied low.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   input  logic [STRB_W-1:0] req_wstrb,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [XLEN-1:0]   rsp_rdata,
   output logic              rsp_err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   state_e             r_state, w_next;
   cnt_t               r_cnt;
   logic               r_write;
   logic [XLEN-1:0]    r_addr, r_wdata;
   logic [STRB_W-1:0]  r_wstrb;

   logic               w_accept, w_enter_resp, w_err;
   logic               w_op_write, w_ram_we, w_ram_re;
   logic [XLEN-1:0]    w_op_addr, w_op_wdata;
   logic [STRB_W-1:0]  w_op_wstrb;
   logic [IDX_W-1:0]   w_idx;

   assign w_accept     = req_valid && (r_state == S_IDLE);
   assign w_enter_resp = (r_state != S_RESP) && (w_next == S_RESP);

   // With zero wait states RESP is entered on the accept edge itself, before
   // the holding registers are loaded, so the live request is used then.
   assign w_op_write = (r_state == S_IDLE) ? req_write : r_write;
   assign w_op_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
   assign w_op_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
   assign w_op_wstrb = (r_state == S_IDLE) ? req_wstrb : r_wstrb;
   assign w_idx      = w_op_addr[IDX_W+1:2];

`ifdef DMEM_ERR_EN
   logic r_err;

   assign w_err = (w_op_addr[1:0] != 2'b00) || ((w_op_addr >> (IDX_W + 2)) != '0);

   // Fault status latched alongside the RAM access, held through RESP
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)            r_err <= 1'b0;
      else if (w_enter_resp) r_err <= w_err;
   end

   assign rsp_err = r_err;
`else
   logic w_unused_addr;

   assign w_err         = 1'b0;
   assign rsp_err       = 1'b0;
   assign w_unused_addr = ^{w_op_addr[XLEN-1:IDX_W+2], w_op_addr[1:0]};
`endif

   assign w_ram_we = w_enter_resp && w_op_write && !w_err;
   assign w_ram_re = !w_op_write && !w_err;

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // FSM next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (req_valid) w_next = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
         S_WAIT:  if (r_cnt == '0) w_next = S_RESP;
         S_RESP:  if (rsp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // FSM outputs: ready only when idle, valid only while responding
   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      case (r_state)
         S_IDLE:  req_ready = 1'b1;
         S_RESP:  rsp_valid = 1'b1;
         default: begin
            req_ready = 1'b0;
            rsp_valid = 1'b0;
         end
      endcase
   end

   // Wait-state counter: loaded on accept, counts down to zero in WAIT
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_cnt <= '0;
      else if (w_accept)
         r_cnt <= (WAIT_CYCLES > 0) ? cnt_t'(WAIT_CYCLES - 1) : '0;
      else if ((r_state == S_WAIT) && (r_cnt != '0))
         r_cnt <= r_cnt - cnt_t'(1);
   end

   // Holding registers: request fields captured at accept, immune to later req_* changes
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_write <= req_write;
         r_addr  <= req_addr;
         r_wdata <= req_wdata;
         r_wstrb <= req_wstrb;
      end
   end

   dmem_ram #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_ram (
      .clk   (clk),
      .reset (reset),
      .acc   (w_enter_resp),
      .re    (w_ram_re),
      .we    (w_ram_we),
      .wstrb (w_op_wstrb),
      .idx   (w_idx),
      .wdata (w_op_wdata),
      .rdata (rsp_rdata)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with WAIT_CYCLES of
// 1, 3 and 0 share one clock; index k selects the instance being driven.
module tb_dmem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n     [3];
   logic        req_valid [3];
   logic        req_ready [3];
   logic        req_write [3];
   logic [31:0] req_addr  [3];
   logic [31:0] req_wdata [3];
   logic [3:0]  req_wstrb [3];
   logic        rsp_valid [3];
   logic        rsp_ready [3];
   logic [31:0] rsp_rdata [3];
   logic        rsp_err   [3];

   int n_checks = 0;
   int n_fail   = 0;

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) u_w1 (
      .clk(clk), .reset(rst_n[0]),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(3)) u_w3 (
      .clk(clk), .reset(rst_n[1]),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .reset(rst_n[2]),
      .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_write(req_write[2]),
      .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_wstrb(req_wstrb[2]),
      .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
      .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_state(input int k, input string tag);
      chk({tag, "/req_ready"}, 32'(req_ready[k]), 32'd1);
      chk({tag, "/rsp_valid"}, 32'(rsp_valid[k]), 32'd0);
      chk({tag, "/rsp_rdata"}, rsp_rdata[k], 32'd0);
      chk({tag, "/rsp_err"},   32'(rsp_err[k]),   32'd0);
   endtask

   // One full transaction with rsp_ready held high; request lines are
   // scrambled right after acceptance to prove only captured fields are used.
   task automatic txn(input int k, input int waitc, input string tag,
                      input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, input logic [31:0] exp_rd, input logic exp_err);
      int lat;
      @(negedge clk);
      chk({tag, "/ready_idle"}, 32'(req_ready[k]), 32'd1);
      req_valid[k] = 1'b1; req_write[k] = wr; req_addr[k] = addr;
      req_wdata[k] = wd;   req_wstrb[k] = st; rsp_ready[k] = 1'b1;
      @(posedge clk); #1;
      req_valid[k] = 1'b0; req_write[k] = ~wr; req_addr[k] = addr ^ 32'h4;
      req_wdata[k] = ~wd;  req_wstrb[k] = ~st;
      lat = 0;
      while (rsp_valid[k] !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "/latency"}, 32'(lat), 32'(waitc));
      chk({tag, "/rdata"}, rsp_rdata[k], exp_rd);
      chk({tag, "/err"}, 32'(rsp_err[k]), 32'(exp_err));
      chk({tag, "/ready_busy"}, 32'(req_ready[k]), 32'd0);
      @(posedge clk); #1;
      chk({tag, "/valid_after_hs"}, 32'(rsp_valid[k]), 32'd0);
      chk({tag, "/ready_after_hs"}, 32'(req_ready[k]), 32'd1);
   endtask

   logic [31:0] exp_b2b [4];
   int          t_acc   [4];

   initial begin
      for (int k = 0; k < 3; k++) begin
         rst_n[k] = 1'b1; req_valid[k] = 1'b0; req_write[k] = 1'b0;
         req_addr[k] = '0; req_wdata[k] = '0; req_wstrb[k] = '0; rsp_ready[k] = 1'b0;
      end
      #2;
      for (int k = 0; k < 3; k++) rst_n[k] = 1'b0;
      #1;
      chk_reset_state(0, "rst_w1");
      chk_reset_state(1, "rst_w3");
      chk_reset_state(2, "rst_w0");
      @(posedge clk); @(negedge clk);
      for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;

      // Store then load, WAIT_CYCLES=1
      txn(0, 1, "st_10", 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0);
      txn(0, 1, "ld_10", 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0);

      // Byte strobes
      txn(0, 1, "st_20", 1'b1, 32'h20, 32'h11223344, 4'b1111, 32'h0, 1'b0);
      txn(0, 1, "st_20_strb", 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
      txn(0, 1, "ld_20", 1'b0, 32'h20, 32'h0, 4'b0000, 32'h11BB33DD, 1'b0);
      txn(0, 1, "st_20_nostrb", 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0);
      txn(0, 1, "ld_20_again", 1'b0, 32'h20, 32'h0, 4'b0000, 32'h11BB33DD, 1'b0);

      // Backpressure: five stalled cycles in RESP, handshake on the sixth
      @(negedge clk);
      req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h10; rsp_ready[0] = 1'b0;
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      @(posedge clk); #1;
      for (int c = 0; c < 5; c++) begin
         chk("bp/rsp_valid", 32'(rsp_valid[0]), 32'd1);
         chk("bp/rsp_rdata", rsp_rdata[0], 32'hDEADBEEF);
         chk("bp/req_ready", 32'(req_ready[0]), 32'd0);
         @(posedge clk); #1;
      end
      chk("bp/still_valid", 32'(rsp_valid[0]), 32'd1);
      rsp_ready[0] = 1'b1;
      @(posedge clk); #1;
      chk("bp/valid_after_hs", 32'(rsp_valid[0]), 32'd0);
      chk("bp/ready_after_hs", 32'(req_ready[0]), 32'd1);

      // Error checks or index wrap, depending on build
      txn(0, 1, "st_0", 1'b1, 32'h0, 32'h0BADCAFE, 4'b1111, 32'h0, 1'b0);
`ifdef DMEM_ERR_EN
      txn(0, 1, "err_misalign", 1'b1, 32'h402, 32'hFFFFFFFF, 4'b1111, 32'h0, 1'b1);
      txn(0, 1, "err_range", 1'b1, 32'h400, 32'h12345678, 4'b1111, 32'h0, 1'b1);
      txn(0, 1, "err_ld_misalign", 1'b0, 32'h11, 32'h0, 4'b0000, 32'h0, 1'b1);
      txn(0, 1, "ld_0_after_err", 1'b0, 32'h0, 32'h0, 4'b0000, 32'h0BADCAFE, 1'b0);
`else
      txn(0, 1, "wrap_ld_402", 1'b0, 32'h402, 32'h0, 4'b0000, 32'h0BADCAFE, 1'b0);
      txn(0, 1, "wrap_ld_13", 1'b0, 32'h13, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0);
`endif

      // Reset mid-WAIT, WAIT_CYCLES=3: pending store must be dropped
      txn(1, 3, "w3_pre", 1'b1, 32'h8, 32'h55AA1234, 4'b1111, 32'h0, 1'b0);
      @(negedge clk);
      req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 32'h8;
      req_wdata[1] = 32'hCAFEF00D; req_wstrb[1] = 4'b1111; rsp_ready[1] = 1'b1;
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      @(posedge clk); #1;
      rst_n[1] = 1'b0;
      #1;
      chk_reset_state(1, "w3_midwait_rst");
      @(negedge clk);
      rst_n[1] = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("w3_no_spurious_rsp", 32'(rsp_valid[1]), 32'd0);
      txn(1, 3, "w3_ld_8", 1'b0, 32'h8, 32'h0, 4'b0000, 32'h55AA1234, 1'b0);

      // WAIT_CYCLES=0 back-to-back loads
      for (int i = 0; i < 4; i++) begin
         exp_b2b[i] = 32'hA5000000 + 32'(i * 32'h01010101);
         txn(2, 0, "w0_fill", 1'b1, 32'h40 + 32'(4 * i), exp_b2b[i], 4'b1111, 32'h0, 1'b0);
      end
      rsp_ready[2] = 1'b1;
      req_write[2] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("b2b/ready", 32'(req_ready[2]), 32'd1);
         req_valid[2] = 1'b1; req_addr[2] = 32'h40 + 32'(4 * i);
         @(posedge clk);
         t_acc[i] = int'($time);
         #1;
         chk("b2b/valid", 32'(rsp_valid[2]), 32'd1);
         chk("b2b/rdata", rsp_rdata[2], exp_b2b[i]);
         chk("b2b/busy", 32'(req_ready[2]), 32'd0);
         @(posedge clk); #1;
         chk("b2b/valid_drop", 32'(rsp_valid[2]), 32'd0);
      end
      req_valid[2] = 1'b0;
      for (int i = 1; i < 4; i++)
         chk("b2b/spacing", 32'(t_acc[i] - t_acc[i-1]), 32'd20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
